// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter sharing one FIFO write port among NUM_REQ producers,
// with zero-latency accept and ownership bursts of up to MAX_BURST writes.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic                       fifo_full
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  logic          r_owner_valid;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_cnt;
  logic          w_burst;
  logic          w_any;
  logic          w_go;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_sel;
  // owner always equals last while owned, so one scan from last+1 covers early release too
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(r_last) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end
  assign w_burst    = r_owner_valid & req[r_owner];
  assign w_go       = rst_n & ~fifo_full & (w_burst | w_any);
  assign w_sel      = w_burst ? r_owner : w_win;
  assign gnt        = w_go ? (NUM_REQ'(1) << w_sel) : '0;
  assign fifo_wr_en = w_go;
  assign fifo_din   = w_go ? req_data[w_sel*WIDTH +: WIDTH] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_valid <= 1'b0;
      r_owner       <= '0;
      r_last        <= IW'(NUM_REQ - 1);
      r_cnt         <= '0;
    end else if (w_go && w_burst) begin
      r_owner_valid <= r_cnt != LAST_CNT;
      r_cnt         <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
    end else if (w_go) begin
      r_last        <= w_win;
      r_owner       <= w_win;
      r_cnt         <= CW'(1);
      r_owner_valid <= MAX_BURST > 1;
    end else if (!fifo_full && r_owner_valid && !req[r_owner]) begin
      r_owner_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of the arbiter with MAX_BURST=4 and MAX_BURST=2 instances
// feeding a behavioural 8-deep FIFO model.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req4, req2, gnt4, gnt2;
  logic [31:0] d4, d2;
  logic        we4, we2, full4, full2;
  logic [7:0]  din4, din2;
  logic [7:0]  fq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          k[4];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .req_data(d4), .gnt(gnt4),
    .fifo_wr_en(we4), .fifo_din(din4), .fifo_full(full4));
  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_data(d2), .gnt(gnt2),
    .fifo_wr_en(we2), .fifo_din(din2), .fifo_full(full2));

  task automatic tick();
    if (we4) fq.push_back(din4);
    @(posedge clk);
    #1;
    full4 = fq.size() == 8;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk += 4;
      if (gnt4 !== 4'b0) begin n_fail++; $display("FAIL reset_gnt4 cyc %0d got %b want 0000", c, gnt4); end
      if (we4 !== 1'b0) begin n_fail++; $display("FAIL reset_we4 cyc %0d got %b want 0", c, we4); end
      if (din4 !== 8'h00) begin n_fail++; $display("FAIL reset_din4 cyc %0d got %h want 00", c, din4); end
      if (gnt2 !== 4'b0) begin n_fail++; $display("FAIL reset_gnt2 cyc %0d got %b want 0000", c, gnt2); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sole_burst();
    req4 = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      d4[23:16] = 8'hA0 + 8'(i);
      #1;
      n_chk += 2;
      if (gnt4 !== 4'b0100) begin n_fail++; $display("FAIL sole_gnt cyc %0d got %b want 0100", i, gnt4); end
      if (din4 !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL sole_din cyc %0d got %h want %h", i, din4, 8'hA0 + 8'(i)); end
      tick();
    end
    req4 = 4'b0;
    n_chk++;
    if (fq.size() != 6) begin n_fail++; $display("FAIL sole_count got %0d want 6", fq.size()); end
    for (int i = 0; i < 6 && i < fq.size(); i++) begin
      n_chk++;
      if (fq[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL sole_order idx %0d got %h want %h", i, fq[i], 8'hA0 + 8'(i)); end
    end
    tick();
    fq.delete();
    full4 = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    int r;
    for (int i = 0; i < 4; i++) k[i] = 0;
    req2 = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      r = (c / 2) % 4;
      eg = 4'b0001 << r;
      for (int i = 0; i < 4; i++) d2[i*8 +: 8] = 8'(16 * i + k[i]);
      #1;
      n_chk += 2;
      if (gnt2 !== eg) begin n_fail++; $display("FAIL rr_gnt cyc %0d got %b want %b", c, gnt2, eg); end
      if (din2 !== 8'(16 * r + k[r])) begin n_fail++; $display("FAIL rr_din cyc %0d got %h want %h", c, din2, 8'(16 * r + k[r])); end
      tick();
      k[r]++;
    end
    req2 = 4'b0;
  endtask

  task automatic test_full_stall();
    req4 = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      d4[15:8] = 8'h40 + 8'(i);
      #1;
      n_chk++;
      if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL fill_gnt cyc %0d got %b want 0010", i, gnt4); end
      tick();
    end
    d4[15:8] = 8'h48;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk += 2;
      if (gnt4 !== 4'b0) begin n_fail++; $display("FAIL stall_gnt cyc %0d got %b want 0000", c, gnt4); end
      if (we4 !== 1'b0) begin n_fail++; $display("FAIL stall_we cyc %0d got %b want 0", c, we4); end
      tick();
    end
    void'(fq.pop_front());
    full4 = 1'b0;
    #1;
    n_chk += 2;
    if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL unstall_gnt got %b want 0010", gnt4); end
    if (din4 !== 8'h48) begin n_fail++; $display("FAIL unstall_din got %h want 48", din4); end
    tick();
    #1;
    n_chk++;
    if (gnt4 !== 4'b0) begin n_fail++; $display("FAIL refull_gnt got %b want 0000", gnt4); end
    req4 = 4'b0;
    n_chk++;
    if (fq.size() != 8) begin n_fail++; $display("FAIL full_count got %0d want 8", fq.size()); end
    for (int i = 0; i < 8 && i < fq.size(); i++) begin
      n_chk++;
      if (fq[i] !== 8'h41 + 8'(i)) begin n_fail++; $display("FAIL full_order idx %0d got %h want %h", i, fq[i], 8'h41 + 8'(i)); end
    end
    fq.delete();
    full4 = 1'b0;
    tick();
  endtask

  task automatic test_early_release();
    req4 = 4'b0001;
    d4 = 32'h53000050;
    #1;
    n_chk++;
    if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL early_own got %b want 0001", gnt4); end
    tick();
    req4 = 4'b1000;
    #1;
    n_chk += 2;
    if (gnt4 !== 4'b1000) begin n_fail++; $display("FAIL early_switch got %b want 1000", gnt4); end
    if (din4 !== 8'h53) begin n_fail++; $display("FAIL early_din got %h want 53", din4); end
    tick();
    req4 = 4'b0011;
    d4 = 32'h00005150;
    #1;
    n_chk++;
    if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL early_last got %b want 0001", gnt4); end
    tick();
    req4 = 4'b0;
    tick();
    fq.delete();
    full4 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    req4 = 4'b0100;
    d4 = 32'h00600000;
    tick();
    tick();
    #1;
    n_chk++;
    if (gnt4 !== 4'b0100) begin n_fail++; $display("FAIL mid_pre got %b want 0100", gnt4); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk += 3;
    if (gnt4 !== 4'b0) begin n_fail++; $display("FAIL mid_rst_gnt got %b want 0000", gnt4); end
    if (we4 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we got %b want 0", we4); end
    if (din4 !== 8'h00) begin n_fail++; $display("FAIL mid_rst_din got %h want 00", din4); end
    fq.delete();
    full4 = 1'b0;
    tick();
    rst_n = 1'b1;
    req4 = 4'b1111;
    d4 = 32'h73727170;
    #1;
    n_chk += 2;
    if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL post_rst_gnt got %b want 0001", gnt4); end
    if (din4 !== 8'h70) begin n_fail++; $display("FAIL post_rst_din got %h want 70", din4); end
    tick();
    req4 = 4'b0;
    n_chk++;
    if (fq.size() != 1 || fq[0] !== 8'h70) begin n_fail++; $display("FAIL post_rst_fifo got size %0d want 1 entry 70", fq.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    req4 = '0; req2 = '0; d4 = '0; d2 = '0;
    full4 = 1'b0; full2 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_sole_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
